// File: rtl/jt12_kon_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt12_kon_wr_pkg
// Description : Shared constants and state type for the YM2612 key-on writer.
// Revision    : 1.0 - initial release
// ============================================================================
package jt12_kon_wr_pkg;

    localparam logic [7:0] JT12_KON_ADDR = 8'h28;
    localparam int         JT12_SLOTS    = 24;
    localparam logic [2:0] JT12_CH_BAD0  = 3'd3;
    localparam logic [2:0] JT12_CH_BAD1  = 3'd7;

    typedef enum logic [0:0] {
        KON_IDLE   = 1'b0,
        KON_ACTIVE = 1'b1
    } kon_state_t;

    // Codes 3 and 7 do not address a channel in slot encoding
    function automatic logic jt12_ch_valid(input logic [2:0] ch);
        return (ch != JT12_CH_BAD0) && (ch != JT12_CH_BAD1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_kon_wr.sv
`default_nettype none
// ============================================================================
// Module      : jt12_kon_wr
// Description : Decodes register 0x28 writes and holds each key-on request
//               for one full operator rotation, with a one-entry pending slot.
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_kon_wr
    import jt12_kon_wr_pkg::*;
#(
    parameter int         SLOTS    = JT12_SLOTS,
    parameter logic [7:0] KON_ADDR = JT12_KON_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic       cpu_a1,
    input  logic [7:0] cpu_din,
    output logic [3:0] keyon_op,
    output logic [2:0] keyon_ch,
    output logic       up_keyon,
    output logic       busy,
    output logic       overrun
);

    localparam logic [4:0] c_LAST = 5'(SLOTS - 1);

    kon_state_t r_state, w_state_nx;
    logic [4:0] r_cnt,   w_cnt_nx;
    logic [3:0] r_op,    w_op_nx;
    logic [2:0] r_ch,    w_ch_nx;
    logic [6:0] r_pend,  w_pend_nx;
    logic       r_pend_vld, w_pend_vld_nx;
    logic       r_overrun,  w_overrun_nx;
    logic [8:0] r_addr;

    logic w_addr_wr;
    logic w_kon;
    logic w_finish;

    assign w_addr_wr = cpu_wr & ~cpu_a0;
    assign w_kon     = cpu_wr & cpu_a0 & ~r_addr[8] & (r_addr[7:0] == KON_ADDR)
                     & jt12_ch_valid(cpu_din[2:0]);
    assign w_finish  = (r_state == KON_ACTIVE) & clk_en & (r_cnt == c_LAST);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_op_nx       = r_op;
        w_ch_nx       = r_ch;
        w_pend_nx     = r_pend;
        w_pend_vld_nx = r_pend_vld;
        w_overrun_nx  = 1'b0;
        case (r_state)
            KON_IDLE: begin
                if (w_kon) begin
                    w_op_nx    = cpu_din[7:4];
                    w_ch_nx    = cpu_din[2:0];
                    w_cnt_nx   = 5'd0;
                    w_state_nx = KON_ACTIVE;
                end
            end
            KON_ACTIVE: begin
                if (clk_en) w_cnt_nx = r_cnt + 5'd1;
                if (w_finish) begin
                    w_cnt_nx = 5'd0;
                    // Pending request takes priority; a coincident write queues behind it
                    if (r_pend_vld) begin
                        {w_op_nx, w_ch_nx} = r_pend;
                        if (w_kon) w_pend_nx = {cpu_din[7:4], cpu_din[2:0]};
                        else       w_pend_vld_nx = 1'b0;
                    end else if (w_kon) begin
                        w_op_nx = cpu_din[7:4];
                        w_ch_nx = cpu_din[2:0];
                    end else begin
                        w_state_nx = KON_IDLE;
                    end
                end else if (w_kon) begin
                    w_pend_nx     = {cpu_din[7:4], cpu_din[2:0]};
                    w_pend_vld_nx = 1'b1;
                    w_overrun_nx  = r_pend_vld;
                end
            end
            default: w_state_nx = KON_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= KON_IDLE;
            r_cnt      <= 5'd0;
            r_op       <= 4'd0;
            r_ch       <= 3'd0;
            r_pend     <= 7'd0;
            r_pend_vld <= 1'b0;
            r_overrun  <= 1'b0;
            r_addr     <= 9'd0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_op       <= w_op_nx;
            r_ch       <= w_ch_nx;
            r_pend     <= w_pend_nx;
            r_pend_vld <= w_pend_vld_nx;
            r_overrun  <= w_overrun_nx;
            if (w_addr_wr) r_addr <= {cpu_a1, cpu_din};
        end
    end

    assign keyon_op = r_op;
    assign keyon_ch = r_ch;
    assign up_keyon = (r_state == KON_ACTIVE);
    assign busy     = (r_state == KON_ACTIVE) | r_pend_vld;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_jt12_kon_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt12_kon_wr
// Description : Directed self-checking bench for the key-on register writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_kon_wr;

    logic       clk = 1'b0;
    logic       rst, clk_en, cpu_wr, cpu_a0, cpu_a1;
    logic [7:0] cpu_din;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       up_keyon, busy, overrun;

    int checks = 0;
    int errors = 0;

    jt12_kon_wr dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .cpu_wr   (cpu_wr),
        .cpu_a0   (cpu_a0),
        .cpu_a1   (cpu_a1),
        .cpu_din  (cpu_din),
        .keyon_op (keyon_op),
        .keyon_ch (keyon_ch),
        .up_keyon (up_keyon),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are stable 1ns after the edge
    task automatic cyc(input logic en, input logic wr, input logic a0,
                       input logic a1, input logic [7:0] d);
        clk_en = en; cpu_wr = wr; cpu_a0 = a0; cpu_a1 = a1; cpu_din = d;
        @(posedge clk);
        #1;
        clk_en = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic wr_addr(input logic a1, input logic [7:0] a);
        cyc(1'b0, 1'b1, 1'b0, a1, a);
    endtask

    task automatic wr_data(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
    endtask

    // n clk_en pulses at 1/6 duty
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] op, input logic [2:0] ch,
                           input logic up, input logic bz);
        chk({tag, ".op"},   8'(keyon_op), 8'(op));
        chk({tag, ".ch"},   8'(keyon_ch), 8'(ch));
        chk({tag, ".up"},   8'(up_keyon), 8'(up));
        chk({tag, ".busy"}, 8'(busy),     8'(bz));
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_a1 = 1'b0; cpu_din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'h0, 3'd0, 1'b0, 1'b0);
        chk("reset.overrun", 8'(overrun), 8'h0);
        rst = 1'b0;

        // Basic key-on, 24 clk_en hold
        wr_addr(1'b0, 8'h28);
        chk_out("addr_only", 4'h0, 3'd0, 1'b0, 1'b0);
        wr_data(8'hF1);
        chk_out("kon_f1", 4'hF, 3'd1, 1'b1, 1'b1);
        pulses(23);
        chk_out("f1_23", 4'hF, 3'd1, 1'b1, 1'b1);
        pulses(1);
        chk_out("f1_done", 4'hF, 3'd1, 1'b0, 1'b0);

        // Ignored writes
        wr_data(8'h13);
        chk_out("ch3", 4'hF, 3'd1, 1'b0, 1'b0);
        wr_data(8'h17);
        chk_out("ch7", 4'hF, 3'd1, 1'b0, 1'b0);
        wr_addr(1'b0, 8'h30);
        wr_data(8'hF0);
        chk_out("addr30", 4'hF, 3'd1, 1'b0, 1'b0);
        wr_addr(1'b1, 8'h28);
        wr_data(8'hF0);
        chk_out("upper_bank", 4'hF, 3'd1, 1'b0, 1'b0);

        // Pending request chains with no gap
        wr_addr(1'b0, 8'h28);
        wr_data(8'h11);
        chk_out("kon_11", 4'h1, 3'd1, 1'b1, 1'b1);
        pulses(4);
        wr_data(8'h22);
        chk_out("pend_22", 4'h1, 3'd1, 1'b1, 1'b1);
        chk("pend_22.overrun", 8'(overrun), 8'h0);
        wr_addr(1'b0, 8'h28);
        pulses(19);
        chk_out("11_23", 4'h1, 3'd1, 1'b1, 1'b1);
        pulses(1);
        chk_out("swap_22", 4'h2, 3'd2, 1'b1, 1'b1);
        pulses(23);
        chk_out("22_23", 4'h2, 3'd2, 1'b1, 1'b1);
        pulses(1);
        chk_out("22_done", 4'h2, 3'd2, 1'b0, 1'b0);

        // Overrun: last pending write wins
        wr_data(8'h11);
        wr_data(8'h22);
        chk("ovr_2nd", 8'(overrun), 8'h0);
        wr_data(8'h44);
        chk("ovr_3rd", 8'(overrun), 8'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovr_pulse_end", 8'(overrun), 8'h0);
        pulses(24);
        chk_out("ovr_44", 4'h4, 3'd4, 1'b1, 1'b1);
        pulses(24);
        chk_out("ovr_done", 4'h4, 3'd4, 1'b0, 1'b0);

        // Key-on coincident with finish, pending empty
        wr_data(8'h21);
        pulses(23);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h15);
        chk_out("coinc_15", 4'h1, 3'd5, 1'b1, 1'b1);
        pulses(23);
        chk_out("15_23", 4'h1, 3'd5, 1'b1, 1'b1);
        pulses(1);
        chk_out("15_done", 4'h1, 3'd5, 1'b0, 1'b0);

        // Reset mid-request
        wr_data(8'hF2);
        pulses(10);
        chk_out("pre_rst", 4'hF, 3'd2, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk_out("mid_rst", 4'h0, 3'd0, 1'b0, 1'b0);
        wr_data(8'hF2);
        chk_out("post_rst_noaddr", 4'h0, 3'd0, 1'b0, 1'b0);
        wr_addr(1'b0, 8'h28);
        wr_data(8'h42);
        chk_out("post_rst_42", 4'h4, 3'd2, 1'b1, 1'b1);
        pulses(23);
        chk_out("42_23", 4'h4, 3'd2, 1'b1, 1'b1);
        pulses(1);
        chk_out("42_done", 4'h4, 3'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt12_kon_wr.md
# jt12_kon_wr

Key-on register writer: decodes CPU writes to YM2612 register 0x28 and drives the `keyon_op`/`keyon_ch`/`up_keyon` update interface consumed by the per-slot key-on shift register. It holds each accepted key-on request for exactly one full 24-slot rotation, so every operator of the target channel sees the update once. A one-entry pending buffer absorbs a second key-on write issued while one is in flight. It sits between the CPU bus interface and the key-on/envelope pipeline.

## Interface
Parameters:
- `SLOTS`, 24: `clk_en` cycles per full operator rotation (hold time of one request)
- `KON_ADDR`, 8'h28: register address decoded (port 0 only)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `clk_en`  in  1  slot-advance enable (same enable as the key-on shift register)
- `cpu_wr`  in  1  single-`clk` write strobe, sampled regardless of `clk_en`
- `cpu_a0`  in  1  0 = address write, 1 = data write
- `cpu_a1`  in  1  port select; 1 = upper bank, never key-on
- `cpu_din`  in  8  write data
- `keyon_op`  out  4  operator mask: bit0 = S1, bit1 = S2, bit2 = S3, bit3 = S4
- `keyon_ch`  out  3  channel in slot encoding (0,1,2,4,5,6)
- `up_keyon`  out  1  update valid; high while a request is active
- `busy`  out  1  active or pending request present
- `overrun`  out  1  one-`clk` pulse when a pending request is overwritten

## Operation
- Address write (`cpu_wr & ~cpu_a0`): latch `{cpu_a1, cpu_din}` as the current address.
- Data write (`cpu_wr & cpu_a0`) is a key-on write only if latched a1 = 0, latched address = `KON_ADDR`, and `cpu_din[2:0]` ∉ {3, 7}.
  - All other data writes are ignored by this block.
  - Valid data is {op = `cpu_din[7:4]`, ch = `cpu_din[2:0]`}. Bits 7:4 map directly to S4..S1.
- States:
  - IDLE: `up_keyon` = 0.
  - ACTIVE: `up_keyon` = 1; a 5-bit count runs 0..SLOTS-1, advancing only on `clk_en`.
- IDLE + key-on write: load op/ch into the outputs, count = 0, go to ACTIVE.
- ACTIVE + key-on write with pending empty: store the write in the pending buffer.
- ACTIVE + key-on write with pending full: overwrite the pending buffer (last write wins) and pulse `overrun`.
- Finish is `clk_en` with count = SLOTS-1:
  - Pending valid: move pending to the outputs, count = 0, stay ACTIVE. `up_keyon` stays high with no gap.
  - Pending empty: go to IDLE. `keyon_op`/`keyon_ch` hold their last values.
- `busy` = ACTIVE | pending_valid.

## Timing
- Reset values:
  - All outputs 0: `keyon_op` 0, `keyon_ch` 0, `up_keyon` 0, `busy` 0, `overrun` 0.
  - State IDLE, count 0, pending cleared, latched address 0.
- Latency: a key-on write at edge N gives `up_keyon`, `keyon_*` and `busy` valid after edge N, independent of `clk_en`.
- Each request is held for exactly SLOTS `clk_en` edges. Cycles with `clk_en` low do not count.
- Finish and key-on write on the same edge:
  - Pending empty: the new write loads directly to the outputs, count restarts at 0, stay ACTIVE.
  - Pending full: pending moves to the outputs and the new write becomes pending. No `overrun`.
- Reset during ACTIVE aborts the request: all outputs are 0 after the reset edge.
- Address write and data write are never on the same edge (single strobe). An address write does not disturb an active request.

## Structure
- Shared package: `JT12_KON_ADDR` (8'h28), `JT12_SLOTS` (24), the invalid-channel codes (3, 7), and the 2-value state enum.
- Single module, no sub-module. The pending buffer is one 7-bit register plus a valid bit.

## Test plan
- Write addr 0x28 then data 0xF1 → next clk `keyon_op`=4'hF, `keyon_ch`=1, `up_keyon`=`busy`=1. After exactly 24 `clk_en` pulses (with `clk_en` at 1/6 duty) both drop to 0; `keyon_op`/`keyon_ch` hold.
- Data 0x13 or 0x17 to 0x28; data 0xF0 after addr 0x30; addr 0x28 with `cpu_a1`=1 → `up_keyon` stays 0 and `busy` stays 0.
- Key-on 0x11, then 0x22 at the 5th `clk_en` → `keyon_op`/`keyon_ch` = 1/1 for 24 `clk_en`, then 2/2 for 24 more. `up_keyon` never drops; `busy` spans 48 `clk_en`.
- 0x11, 0x22, 0x44 all while active → one `overrun` pulse on the third write; the second request is 4/4; 0x22 never appears.
- Key-on 0x15 issued on the same edge as finish with pending empty → count restarts at 0, `keyon_op`=1, `keyon_ch`=5, 24 further `clk_en` high.
- Assert `rst` at count 10 → all outputs 0 next clk. A subsequent write restarts cleanly with the full 24-`clk_en` hold.
